// File: rtl/seg_sweep.sv
// Multiplexed seven-segment "sweep" driver: a glyph bounces across NUM_DIGITS digits
// (TOP phase outward, BOT phase back). Optional trail digit: define SEG_SWEEP_TRAIL_EN.
module seg_sweep #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int STEP_DIV    = 50000000,
  parameter bit SEG_ON      = 1'b0,
  parameter bit AN_ON       = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          dir,
  input  logic                          pause,
  input  logic [6:0]                    glyph_top,
  input  logic [6:0]                    glyph_bot,
  output logic [NUM_DIGITS-1:0]         AN,
  output logic                          CA,
  output logic                          CB,
  output logic                          CC,
  output logic                          CD,
  output logic                          CE,
  output logic                          CF,
  output logic                          CG,
  output logic [1:0]                    phase,
  output logic [$clog2(NUM_DIGITS)-1:0] pos,
  output logic                          step
);

  localparam int PW = $clog2(NUM_DIGITS);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(STEP_DIV);
  localparam logic [PW-1:0] POS_LAST  = PW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam bit SEG_OFF = ~SEG_ON;
  localparam bit AN_OFF  = ~AN_ON;

  // Encodings double as the phase output code.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_TOP  = 2'b01,
    S_BOT  = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           pos_q, pos_d;
  logic [SW-1:0]           div_q, div_d;
  logic                    step_q, step_d;
  logic                    tick;
  logic [RW-1:0]           ref_q, ref_d;
  logic [PW-1:0]           slot_q, slot_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [6:0]              seg_on_d;
  logic [PW-1:0]           lit_digit;
  logic                    active;
  logic [6:0]              glyph;

  // Sweep FSM: divider wrap is the tick that moves pos or flips phase.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    div_d   = div_q;
    step_d  = 1'b0;
    tick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        pos_d = '0;
        div_d = '0;
        if (en) state_d = S_TOP;
      end
      S_TOP, S_BOT: begin
        if (!en) begin
          state_d = S_IDLE;
          pos_d   = '0;
          div_d   = '0;
        end else if (!pause) begin
          if (div_q == STEP_LAST) begin
            div_d = '0;
            tick  = 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        if (tick) begin
          step_d = 1'b1;
          if (state_q == S_TOP) begin
            if (pos_q == POS_LAST) state_d = S_BOT;
            else                   pos_d   = pos_q + 1'b1;
          end else begin
            if (pos_q == '0) state_d = S_TOP;
            else             pos_d   = pos_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pos_d   = '0;
        div_d   = '0;
      end
    endcase
  end

  // Scan counter runs regardless of sweep state.
  always_comb begin
    ref_d  = ref_q + 1'b1;
    slot_d = slot_q;
    if (ref_q == REF_LAST) begin
      ref_d  = '0;
      slot_d = (slot_q == POS_LAST) ? '0 : slot_q + 1'b1;
    end
  end

`ifdef SEG_SWEEP_TRAIL_EN
  logic [PW-1:0] prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [PW-1:0] trail_digit;

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (state_d == S_IDLE) begin
      prev_d     = '0;
      prev_vld_d = 1'b0;
    end else if (tick) begin
      prev_d     = pos_q;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign trail_digit = dir ? prev_q : POS_LAST - prev_q;
`endif

  // en is folded in so dropping it blanks the outputs on the same edge the FSM idles.
  assign active    = en && (state_q != S_IDLE);
  assign lit_digit = dir ? pos_q : POS_LAST - pos_q;
  assign glyph     = (state_q == S_BOT) ? glyph_bot : glyph_top;

  always_comb begin
    an_d     = {NUM_DIGITS{AN_OFF}};
    seg_on_d = 7'b0000000;
    if (active && (slot_q == lit_digit)) begin
      an_d[slot_q] = AN_ON;
      seg_on_d     = glyph;
    end
`ifdef SEG_SWEEP_TRAIL_EN
    else if (active && prev_vld_q && (slot_q == trail_digit)) begin
      an_d[slot_q] = AN_ON;
      seg_on_d     = 7'b1000000;
    end
`endif
    seg_d = SEG_ON ? seg_on_d : ~seg_on_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      div_q   <= '0;
      step_q  <= 1'b0;
      ref_q   <= '0;
      slot_q  <= '0;
      an_q    <= {NUM_DIGITS{AN_OFF}};
      seg_q   <= {7{SEG_OFF}};
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      step_q  <= step_d;
      ref_q   <= ref_d;
      slot_q  <= slot_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign AN    = an_q;
  assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
  assign phase = state_q;
  assign pos   = pos_q;
  assign step  = step_q;

endmodule

// File: tb/tb_seg_sweep.sv
// Directed bench for seg_sweep (NUM_DIGITS=4, REFRESH_DIV=1, STEP_DIV=8, active-low).
// Trail expectations switch on when SEG_SWEEP_TRAIL_EN is defined.
module tb_seg_sweep;
  logic       clk = 1'b0;
  logic       rst, en, dir, pause;
  logic [6:0] glyph_top, glyph_bot;
  logic [3:0] an;
  logic       ca, cb, cc, cd, ce, cf, cg;
  logic [1:0] phase;
  logic [1:0] pos;
  logic       step;

  int checks  = 0;
  int errors  = 0;
  int cyc_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] an_and;
  logic [6:0] seg_by [4];

  seg_sweep #(
    .NUM_DIGITS(4), .REFRESH_DIV(1), .STEP_DIV(8), .SEG_ON(1'b0), .AN_ON(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .pause(pause),
    .glyph_top(glyph_top), .glyph_bot(glyph_bot),
    .AN(an), .CA(ca), .CB(cb), .CC(cc), .CD(cd), .CE(ce), .CF(cf), .CG(cg),
    .phase(phase), .pos(pos), .step(step)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_step();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (step !== 1'b1 && k < 200);
    if (step !== 1'b1) check("step_timeout", 32'd0, 32'd1);
  endtask

  // Four consecutive samples cover every scan slot when REFRESH_DIV=1.
  task automatic scan();
    an_and = 4'hf;
    for (int i = 0; i < 4; i++) seg_by[i] = 7'h7f;
    for (int s = 0; s < 4; s++) begin
      an_and &= an;
      for (int i = 0; i < 4; i++)
        if (an[i] == 1'b0) seg_by[i] = {cg, cf, ce, cd, cc, cb, ca};
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pause = 1'b0;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ev;
    logic [3:0] exp_an;
    logic       stepped, moved;
    int d, dprev, prev_pos, t_prev, t0;

    rst = 1'b1; en = 1'b0; dir = 1'b0; pause = 1'b0;
    glyph_top = 7'h63; glyph_bot = 7'h5c;
    cycles(3);
    check("rst_phase", phase, 2'b00);
    check("rst_pos", pos, 2'd0);
    check("rst_an", an, 4'hf);
    check("rst_seg", {cg, cf, ce, cd, cc, cb, ca}, 7'h7f);
    check("rst_step", step, 1'b0);

    // full sweep, dir=0
    rst = 1'b0; en = 1'b1;
    cycles(1);
    check("start_state", {phase, pos}, 4'b0100);
    cycles(1);
    scan();
    check("p0_an", an_and, 4'b0111);
    check("p0_seg", seg_by[3], 7'h1c);

    exp_q = '{4'b0101, 4'b0110, 4'b0111, 4'b1011, 4'b1010, 4'b1001, 4'b1000, 4'b0100};
    prev_pos = 0;
    t_prev   = 0;
    for (int k = 0; k < 8; k++) begin
      wait_step();
      ev = exp_q.pop_front();
      check("step_state", {phase, pos}, ev);
      if (k > 0) check("step_period", cyc_cnt - t_prev, 8);
      t_prev = cyc_cnt;
      cycles(1);
      check("step_width", step, 1'b0);
      scan();
      d      = 3 - int'(ev[1:0]);
      dprev  = 3 - prev_pos;
      exp_an = 4'hf & ~(4'b0001 << d);
`ifdef SEG_SWEEP_TRAIL_EN
      exp_an &= ~(4'b0001 << dprev);
      if (dprev != d) check("trail_seg", seg_by[dprev], 7'h3f);
`else
      if (dprev != d) check("no_trail", seg_by[dprev], 7'h7f);
`endif
      check("scan_an", an_and, exp_an);
      check("scan_seg", seg_by[d], (ev[3:2] == 2'b10) ? 7'h1c ^ 7'h3f : 7'h1c);
      prev_pos = int'(ev[1:0]);
    end

    // dir=1, then flip dir while paused at pos 3
    do_reset();
    dir = 1'b1; en = 1'b1;
    cycles(2);
    scan();
    check("dir1_p0_an", an_and, 4'b1110);
    check("dir1_p0_seg", seg_by[0], 7'h1c);
    repeat (3) wait_step();
    check("dir1_p3_state", {phase, pos}, 4'b0111);
    cycles(1);
    scan();
`ifdef SEG_SWEEP_TRAIL_EN
    check("dir1_p3_an", an_and, 4'b0011);
`else
    check("dir1_p3_an", an_and, 4'b0111);
`endif
    check("dir1_p3_seg", seg_by[3], 7'h1c);
    pause = 1'b1; dir = 1'b0;
    cycles(1);
    scan();
`ifdef SEG_SWEEP_TRAIL_EN
    check("dirflip_an", an_and, 4'b1100);
`else
    check("dirflip_an", an_and, 4'b1110);
`endif
    check("dirflip_state", {phase, pos}, 4'b0111);
    pause = 1'b0;

    // pause with tick due at pos 1
    do_reset();
    dir = 1'b0; en = 1'b1;
    wait_step();
    check("pause_pos1", {phase, pos}, 4'b0101);
    cycles(7);
    pause = 1'b1;
    stepped = 1'b0; moved = 1'b0;
    repeat (20) begin
      @(negedge clk);
      stepped |= step;
      moved   |= (pos != 2'd1);
    end
    check("pause_nostep", stepped, 1'b0);
    check("pause_hold", moved, 1'b0);
    pause = 1'b0;
    t0 = cyc_cnt;
    wait_step();
    check("pause_resume", cyc_cnt - t0, 1);
    check("pause_pos2", {phase, pos}, 4'b0110);

    // en drop at pos 3 TOP
    wait_step();
    check("endrop_pre", {phase, pos}, 4'b0111);
    en = 1'b0;
    cycles(1);
    check("endrop_state", {phase, pos}, 4'b0000);
    check("endrop_an", an, 4'hf);
    check("endrop_seg", {cg, cf, ce, cd, cc, cb, ca}, 7'h7f);
    scan();
    check("idle_an", an_and, 4'hf);
    en = 1'b1;
    t0 = cyc_cnt;
    cycles(1);
    check("restart_state", {phase, pos}, 4'b0100);
    wait_step();
    check("restart_period", cyc_cnt - t0, 9);
    check("restart_pos", {phase, pos}, 4'b0101);

    // reset mid-BOT at pos 2, en held high
    repeat (4) wait_step();
    check("bot2_state", {phase, pos}, 4'b1010);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    check("midrst_state", {phase, pos}, 4'b0000);
    check("midrst_an", an, 4'hf);
    check("midrst_seg", {cg, cf, ce, cd, cc, cb, ca}, 7'h7f);
    check("midrst_step", step, 1'b0);
    rst = 1'b0;
    t0 = cyc_cnt;
    wait_step();
    check("postrst_period", cyc_cnt - t0, 9);
    check("postrst_state", {phase, pos}, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
